// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and named architectural register indices.
package cpu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;

  localparam reg_idx_t REG_ZERO = 5'd0;
  localparam reg_idx_t REG_AT   = 5'd1;
  localparam reg_idx_t REG_V0   = 5'd2;
  localparam reg_idx_t REG_SP   = 5'd29;
  localparam reg_idx_t REG_FP   = 5'd30;
  localparam reg_idx_t REG_RA   = 5'd31;

endpackage

// File: rtl/wb_mux.sv
// Writeback select: load result or ALU result. Shared with EX-stage forwarding.
module wb_mux #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              MemtoReg,
  input  logic [DATA_W-1:0] ALUOut,
  input  logic [DATA_W-1:0] ReadData,
  output logic [DATA_W-1:0] WriteData
);

  // 2:1 select, valid every cycle regardless of commit enable
  always_comb begin
    WriteData = MemtoReg ? ReadData : ALUOut;
  end

endmodule

// File: rtl/wb_regfile.sv
// MEM/WB consumer: writeback mux plus 32-entry register file with two
// write-first bypassed read ports and one committed-state debug port.
module wb_regfile
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W    = cpu_pkg::DATA_W,
  parameter int unsigned ADDR_W    = cpu_pkg::ADDR_W,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              RegWrite,
  input  logic              MemtoReg,
  input  logic [DATA_W-1:0] ALUOut,
  input  logic [DATA_W-1:0] ReadData,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  input  logic [ADDR_W-1:0] DbgReg,
  output logic [DATA_W-1:0] DbgData,
  output logic [DATA_W-1:0] WriteData
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] IDX_ZERO = ADDR_W'(REG_ZERO);

  // Index 0 is hardwired, so storage starts at 1.
  logic [DATA_W-1:0] regs [DEPTH-1:1];

  logic commit;
  logic byp1;
  logic byp2;

  wb_mux #(
    .DATA_W(DATA_W)
  ) u_wb_mux (
    .MemtoReg (MemtoReg),
    .ALUOut   (ALUOut),
    .ReadData (ReadData),
    .WriteData(WriteData)
  );

  // Commit qualifier; RegWrite gates first so a don't-care WriteReg is masked.
  always_comb begin
    commit = RegWrite && (WriteReg != IDX_ZERO);
  end

  // Register array: async clear to RESET_VAL, write on rising edge
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int unsigned i = 1; i < DEPTH; i++) begin
        regs[i] <= RESET_VAL;
      end
    end else if (commit) begin
      regs[WriteReg] <= WriteData;
    end
  end

  // Same-cycle bypass match per port; suppressed while reset is held
  always_comb begin
    byp1 = RST_n && commit && (WriteReg == ReadReg1);
    byp2 = RST_n && commit && (WriteReg == ReadReg2);
  end

  // Read port 1: zero register, then bypass, then stored value
  always_comb begin
    ReadData1 = '0;
    if (ReadReg1 != IDX_ZERO) begin
      ReadData1 = byp1 ? WriteData : regs[ReadReg1];
    end
  end

  // Read port 2: zero register, then bypass, then stored value
  always_comb begin
    ReadData2 = '0;
    if (ReadReg2 != IDX_ZERO) begin
      ReadData2 = byp2 ? WriteData : regs[ReadReg2];
    end
  end

  // Debug port: committed state only, no bypass
  always_comb begin
    DbgData = '0;
    if (DbgReg != IDX_ZERO) begin
      DbgData = regs[DbgReg];
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed, table-driven bench for wb_regfile.
module tb_wb_regfile;

  logic        CLK;
  logic        RST_n;
  logic        RegWrite;
  logic        MemtoReg;
  logic [31:0] ALUOut;
  logic [31:0] ReadData;
  logic [4:0]  WriteReg;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic [4:0]  DbgReg;
  logic [31:0] DbgData;
  logic [31:0] WriteData;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  wb_regfile #(
    .DATA_W   (32),
    .ADDR_W   (5),
    .RESET_VAL(32'h0)
  ) dut (
    .CLK      (CLK),
    .RST_n    (RST_n),
    .RegWrite (RegWrite),
    .MemtoReg (MemtoReg),
    .ALUOut   (ALUOut),
    .ReadData (ReadData),
    .WriteReg (WriteReg),
    .ReadReg1 (ReadReg1),
    .ReadReg2 (ReadReg2),
    .ReadData1(ReadData1),
    .ReadData2(ReadData2),
    .DbgReg   (DbgReg),
    .DbgData  (DbgData),
    .WriteData(WriteData)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic        rw;
    logic        m2r;
    logic [31:0] alu;
    logic [31:0] rd;
    logic [4:0]  wr;
    logic [4:0]  rr1;
    logic [4:0]  rr2;
    logic [4:0]  dbg;
    logic [31:0] exp_wd;
    logic [31:0] exp_rd1;
    logic [31:0] exp_rd2;
    logic [31:0] exp_dbg;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rw, input logic m2r, input logic [31:0] alu,
                       input logic [31:0] rd, input logic [4:0] wr);
    RegWrite = rw;
    MemtoReg = m2r;
    ALUOut   = alu;
    ReadData = rd;
    WriteReg = wr;
  endtask

  initial begin
    logic [31:0] v1;
    logic [31:0] v2;

    // Each vector is checked before its own edge, then committed on that edge.
    vecs[0] = '{1'b1, 1'b0, 32'h1234_5678, 32'h0, 5'd8, 5'd8, 5'd0, 5'd8,
                32'h1234_5678, 32'h1234_5678, 32'h0, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 32'h0, 32'hDEAD_BEEF, 5'd9, 5'd8, 5'd9, 5'd8,
                32'hDEAD_BEEF, 32'h1234_5678, 32'hDEAD_BEEF, 32'h1234_5678};
    vecs[2] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 5'd0, 5'd0, 5'd9, 5'd9,
                32'hFFFF_FFFF, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[3] = '{1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd8, 5'd0,
                32'h0, 32'h0, 32'h1234_5678, 32'h0};
    vecs[4] = '{1'b1, 1'b0, 32'h11, 32'h0, 5'd3, 5'd3, 5'd3, 5'd3,
                32'h11, 32'h11, 32'h11, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 32'h22, 32'h0, 5'd3, 5'd3, 5'd3, 5'd3,
                32'h22, 32'h22, 32'h22, 32'h11};
    vecs[6] = '{1'b0, 1'b0, 32'h99, 32'h0, 5'd3, 5'd3, 5'd9, 5'd3,
                32'h99, 32'h22, 32'hDEAD_BEEF, 32'h22};
    vecs[7] = '{1'b0, 1'b1, 32'h0, 32'h77, 5'd3, 5'd3, 5'd8, 5'd3,
                32'h77, 32'h22, 32'h1234_5678, 32'h22};
    vecs[8] = '{1'b1, 1'b1, 32'h0, 32'hCAFE_0001, 5'd31, 5'd31, 5'd3, 5'd31,
                32'hCAFE_0001, 32'hCAFE_0001, 32'h22, 32'h0};
    vecs[9] = '{1'b0, 1'b0, 32'h0, 32'h0, 5'd31, 5'd31, 5'd0, 5'd31,
                32'h0, 32'hCAFE_0001, 32'h0, 32'hCAFE_0001};

    RST_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    ReadReg1 = 5'd0;
    ReadReg2 = 5'd0;
    DbgReg   = 5'd0;
    repeat (2) @(negedge CLK);
    RST_n = 1'b1;

    // Put a non-reset value in reg5 so the mid-cycle reset has something to clear.
    drive(1'b1, 1'b0, 32'hAAAA_AAAA, 32'h0, 5'd5);
    @(posedge CLK);
    #1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    DbgReg = 5'd5;
    #1;
    chk("pre_reset_reg5", DbgData, 32'hAAAA_AAAA);

    // Mid-cycle async reset with a write to reg5 pending.
    @(negedge CLK);
    #2;
    drive(1'b1, 1'b0, 32'h5555_5555, 32'h0, 5'd5);
    ReadReg1 = 5'd5;
    RST_n = 1'b0;
    #1;
    chk("async_reset_dbg5", DbgData, 32'h0);
    chk("reset_no_bypass", ReadData1, 32'h0);
    for (int i = 0; i < 32; i++) begin
      DbgReg = 5'(i);
      #0.1;
      chk($sformatf("reset_dbg[%0d]", i), DbgData, 32'h0);
    end
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    RST_n = 1'b1;
    DbgReg = 5'd5;
    #1;
    chk("reg5_after_reset", DbgData, 32'h0);

    // Table vectors; first one commits on the first edge after release.
    for (int k = 0; k < 10; k++) begin
      drive(vecs[k].rw, vecs[k].m2r, vecs[k].alu, vecs[k].rd, vecs[k].wr);
      ReadReg1 = vecs[k].rr1;
      ReadReg2 = vecs[k].rr2;
      DbgReg   = vecs[k].dbg;
      #1;
      chk($sformatf("v%0d_wd", k),  WriteData, vecs[k].exp_wd);
      chk($sformatf("v%0d_rd1", k), ReadData1, vecs[k].exp_rd1);
      chk($sformatf("v%0d_rd2", k), ReadData2, vecs[k].exp_rd2);
      chk($sformatf("v%0d_dbg", k), DbgData,   vecs[k].exp_dbg);
      @(negedge CLK);
    end

    // Full sweep: write 1..31 on consecutive cycles, alternating mux source.
    for (int i = 1; i < 32; i++) begin
      v1 = 32'h0101_0101 * 32'(i);
      if (i % 2 == 1) drive(1'b1, 1'b1, 32'hBAD0_0000, v1, 5'(i));
      else            drive(1'b1, 1'b0, v1, 32'hBAD0_0000, 5'(i));
      @(negedge CLK);
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    for (int i = 1; i < 32; i++) begin
      ReadReg1 = 5'(i);
      ReadReg2 = 5'(32 - i);
      DbgReg   = 5'(i);
      v1 = 32'h0101_0101 * 32'(i);
      v2 = 32'h0101_0101 * 32'(32 - i);
      #1;
      chk($sformatf("sweep_rd1[%0d]", i), ReadData1, v1);
      chk($sformatf("sweep_rd2[%0d]", 32 - i), ReadData2, v2);
      chk($sformatf("sweep_dbg[%0d]", i), DbgData, v1);
    end
    ReadReg1 = 5'd0;
    DbgReg   = 5'd0;
    #1;
    chk("sweep_rd1_reg0", ReadData1, 32'h0);
    chk("sweep_dbg_reg0", DbgData, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Consumer end of the MEM/WB pipeline register: takes the registered writeback controls and data, applies the MemtoReg writeback mux, and commits results to the 32-entry architectural register file.
- Serves the ID stage with two combinational read ports, plus a third read port for debug/testbench.
- Write-first bypass lets an ID-stage read in the same cycle as a WB write see the new value, so no WB→ID hazard exists.

Parameters:
- DATA_W, 32, register and datapath width
- ADDR_W, 5, register index width; depth = 2**ADDR_W
- RESET_VAL, 0, value loaded into every register on reset

Ports:
- CLK  input  1  single clock; all state updates on rising edge
- RST_n  input  1  asynchronous, active-low reset
- RegWrite  input  1  from MEM/WB: commit enable
- MemtoReg  input  1  from MEM/WB: 1 selects ReadData, 0 selects ALUOut
- ALUOut  input  DATA_W  from MEM/WB: ALU result
- ReadData  input  DATA_W  from MEM/WB: data-memory load result
- WriteReg  input  ADDR_W  from MEM/WB: destination register index
- ReadReg1  input  ADDR_W  ID-stage source index rs
- ReadReg2  input  ADDR_W  ID-stage source index rt
- ReadData1  output  DATA_W  value of rs, combinational
- ReadData2  output  DATA_W  value of rt, combinational
- DbgReg  input  ADDR_W  debug read index
- DbgData  output  DATA_W  debug read value, combinational, no bypass
- WriteData  output  DATA_W  writeback mux result, exported for EX-stage forwarding

Behaviour:
- Writeback mux: WriteData = MemtoReg ? ReadData : ALUOut. Purely combinational and valid every cycle, regardless of RegWrite.
- Commit: on posedge CLK with RST_n high, if RegWrite=1 and WriteReg≠0, then reg[WriteReg] <= WriteData. Nothing else changes.
- Register 0 is hardwired:
  - Writes to index 0 are discarded.
  - Reads of index 0 return 0 on all three ports, independent of RESET_VAL and bypass.
  - No storage is implemented for index 0.
- Reads: ReadDataN = (ReadRegN==0) ? 0 : (RegWrite && WriteReg==ReadRegN) ? WriteData : reg[ReadRegN].
  - Bypass is combinational on the same cycle as the write; read latency is 0 cycles.
- Debug port: DbgData = (DbgReg==0) ? 0 : reg[DbgReg], with no bypass. It shows committed state only.
- Reset:
  - When RST_n is low, all registers 1..31 are set to RESET_VAL immediately, without waiting for a clock edge.
  - While RST_n is low, commits are blocked and read ports return RESET_VAL for indices 1..31.
  - The bypass is also suppressed while RST_n is low.
- Reset deasserted mid-operation: the first commit can occur on the first rising edge after RST_n goes high. The registered inputs need no special handling.
- Simultaneous events:
  - ReadReg1 == ReadReg2 == WriteReg ≠ 0 with RegWrite: both ports return WriteData.
  - RegWrite=0 with matching indices: no bypass; ports return stored values.
- X handling: when RegWrite=0, WriteReg/ALUOut/ReadData may be X with no effect on state or read ports. This is asserted in verification.
- No internal counters or FSM. Sequential state is the 31×DATA_W array.

Decomposition:
- Shared package cpu_pkg: DATA_W, ADDR_W, REG_ZERO=0, and the named register indices used by tests (e.g. REG_RA=31).
- One natural sub-module, wb_mux (2:1 writeback select). It is shared with EX-stage forwarding logic, so the mux is not duplicated.

Test Plan:
- Reset: assert RST_n=0 mid-cycle, then read all 32 indices via DbgReg → 0 everywhere. Drive RegWrite=1, WriteReg=5 during reset → reg5 still 0 after reset release.
- Basic commit: RegWrite=1, MemtoReg=0, ALUOut=0x1234_5678, WriteReg=8, one edge → DbgReg=8 reads 0x1234_5678. Then MemtoReg=1, ReadData=0xDEAD_BEEF, WriteReg=9 → reg9=0xDEAD_BEEF, reg8 unchanged.
- Zero register: RegWrite=1, WriteReg=0, ALUOut=0xFFFF_FFFF → ReadData1 with ReadReg1=0 is 0 both before and after the edge; DbgReg=0 reads 0.
- Bypass: reg3 holds 0x11; same cycle RegWrite=1, WriteReg=3, ALUOut=0x22, ReadReg1=ReadReg2=3 → both ports 0x22 before the edge, DbgData 0x11 before and 0x22 after.
- No bypass when disabled: RegWrite=0, WriteReg=3, ALUOut=0x99, ReadReg1=3 → ReadData1 stays 0x22 and reg3 is unchanged after the edge.
- Full sweep: write i*0x0101_0101 to registers 1..31 on consecutive cycles, then read back pairs (i, 32-i) on both ports → exact match; reg0=0.
